// File: rtl/register_pipe.sv
// ============================================================================
// Module      : register_pipe
// Description : DEPTH-stage valid/ready register pipeline. Each stage has a
//               main register and a skid register, so every ready is registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_pipe #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 out_data,
    input  logic                             out_ready,
    output logic [$clog2(2*DEPTH+1)-1:0]     count
);

    localparam int COUNT_W = $clog2(2*DEPTH+1);

    logic [DEPTH-1:0]  w_main_v;
    logic [DEPTH-1:0]  w_skid_v;
    logic [WIDTH-1:0]  w_main_d [DEPTH];
    logic              w_run;
    logic              w_acc;
    logic              w_out_xfer;
    logic [COUNT_W-1:0] r_count;

    assign w_run = en & ~flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              r_main_v;
        logic              r_skid_v;
        logic [WIDTH-1:0]  r_main_d;
        logic [WIDTH-1:0]  r_skid_d;
        logic              w_up_valid;
        logic [WIDTH-1:0]  w_up_data;
        logic              w_dn_ready;
        logic              w_up_xfer;
        logic              w_consume;

        if (i == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_link
            assign w_up_valid = w_main_v[i-1];
            assign w_up_data  = w_main_d[i-1];
        end

        // Downstream ready is the next stage's registered skid-empty flag.
        if (i == DEPTH-1) begin : g_tail
            assign w_dn_ready = out_ready;
        end else begin : g_mid
            assign w_dn_ready = ~w_skid_v[i+1];
        end

        assign w_up_xfer = w_up_valid & ~r_skid_v;
        assign w_consume = r_main_v & w_dn_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
                r_main_d <= RESET_VAL;
                r_skid_d <= RESET_VAL;
            end else if (w_run) begin
                if (r_skid_v) begin
                    if (w_consume || !r_main_v) begin
                        r_main_v <= 1'b1;
                        r_main_d <= r_skid_d;
                        r_skid_v <= 1'b0;
                    end
                end else if (w_up_xfer) begin
                    if (w_consume || !r_main_v) begin
                        r_main_v <= 1'b1;
                        r_main_d <= w_up_data;
                    end else begin
                        r_skid_v <= 1'b1;
                        r_skid_d <= w_up_data;
                    end
                end else if (w_consume) begin
                    r_main_v <= 1'b0;
                end
            end else if (en) begin
                // Flush drops the words but leaves the data registers as they are.
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
            end
        end

        assign w_main_v[i] = r_main_v;
        assign w_skid_v[i] = r_skid_v;
        assign w_main_d[i] = r_main_d;
    end

    assign w_acc      = w_run & in_valid & ~w_skid_v[0];
    assign w_out_xfer = w_run & w_main_v[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            if (flush) begin
                r_count <= '0;
            end else if (w_acc && !w_out_xfer) begin
                r_count <= r_count + COUNT_W'(1);
            end else if (!w_acc && w_out_xfer) begin
                r_count <= r_count - COUNT_W'(1);
            end
        end
    end

    assign in_ready  = ~w_skid_v[0] & en;
    assign out_valid = w_main_v[DEPTH-1] & en;
    assign out_data  = w_main_d[DEPTH-1];
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_register_pipe.sv
// ============================================================================
// Module      : tb_register_pipe
// Description : Directed and random scoreboard bench for register_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              flush;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready;
    logic [2:0]        count;

    register_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad   = 0;
    int              mcount = 0;
    int              ncyc  = 0;
    logic            last_acc;
    logic            last_xfer;
    logic [WIDTH-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, update the model, check count after the edge.
    task automatic tick();
        logic [WIDTH-1:0] exp_d;
        @(negedge clk);
        last_acc  = 1'b0;
        last_xfer = 1'b0;
        if (rst_n) begin
            if (!en) begin
                chk("frz_in_ready", in_ready, 0);
                chk("frz_out_valid", out_valid, 0);
            end else begin
                if (mcount == 2*DEPTH) chk("full_in_ready", in_ready, 0);
                if (mcount == 0)       chk("empty_out_valid", out_valid, 0);
            end
            last_acc  = en && !flush && in_valid && in_ready;
            last_xfer = en && !flush && out_valid && out_ready;
            if (last_xfer) begin
                chk("out_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_d = sb.pop_front();
                    chk("out_data", out_data, exp_d);
                end
            end
            if (en && flush) begin
                sb.delete();
                mcount = 0;
            end else begin
                if (last_acc) sb.push_back(in_data);
                mcount = mcount + int'(last_acc) - int'(last_xfer);
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
        if (rst_n) chk("count", count, mcount);
    endtask

    initial begin
        int sent, nout, first_acc, first_out, last_out, accepted;
        logic [WIDTH-1:0] held;

        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Streaming
        out_ready = 1'b1; sent = 0; nout = 0;
        first_acc = -1; first_out = -1; last_out = -1;
        for (int k = 0; k < 22; k++) begin
            in_valid = (sent < 16);
            in_data  = WIDTH'(sent + 1);
            tick();
            if (last_acc) begin
                if (first_acc < 0) first_acc = k;
                sent++;
            end
            if (last_xfer) begin
                if (first_out < 0) first_out = k;
                last_out = k;
                nout++;
            end
            chk("stream_cnt_le2", count <= 3'd2, 1);
        end
        chk("stream_latency", first_out - first_acc, DEPTH);
        chk("stream_nout", nout, 16);
        chk("stream_rate", last_out - first_out, 15);

        // Back-pressure
        out_ready = 1'b0; in_valid = 1'b1; sent = 0;
        for (int k = 0; k < 6; k++) begin
            in_data = WIDTH'(8'hA0 + sent);
            tick();
            if (last_acc) sent++;
        end
        chk("bp_accepts", sent, 4);
        chk("bp_count", count, 4);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1; nout = 0; first_out = -1; last_out = -1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (last_xfer) begin
                if (first_out < 0) first_out = k;
                last_out = k;
                nout++;
            end
        end
        chk("bp_nout", nout, 4);
        chk("bp_consecutive", last_out - first_out, 3);

        // Flush
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = WIDTH'(8'h31 + k);
            tick();
        end
        chk("fl_pre_count", count, 3);
        flush = 1'b1; in_data = 8'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();

        // Enable freeze
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hC0; tick();
        in_data = 8'hC1; tick();
        held = out_data;
        en = 1'b0; in_data = 8'hEE; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("frz_count", count, 2);
        chk("frz_out_data_hold", out_data, held);
        en = 1'b1; in_valid = 1'b0; nout = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (last_xfer) nout++;
        end
        chk("frz_nout", nout, 2);
        chk("frz_sb_empty", sb.size(), 0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = WIDTH'(8'h71 + k);
            tick();
        end
        chk("ar_pre_count", count, 3);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_count", count, 0);
        sb.delete(); mcount = 0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", in_ready, 1);

        // Random traffic
        accepted = 0;
        for (int k = 0; k < 30000 && accepted < 1000; k++) begin
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 2);
            in_data   = WIDTH'($urandom);
            tick();
            if (last_acc) accepted++;
        end
        chk("rand_accepted", accepted >= 1000, 1);
        en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("rand_drained", sb.size(), 0);
        chk("rand_final_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
